// File: rtl/wshb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arb_pkg
//  Description : Shared types and constants for the two-requester Wishbone
//                arbiter (arbiter state encoding, default ack timeout).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package wshb_arb_pkg;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    // Default number of cycles a granted transfer may wait for ack/err.
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage
`default_nettype wire

// File: rtl/wshb_if.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_if
//  Description : Wishbone classic bus bundle.
//  Ports       : master modport drives cyc/stb/we/adr/dat_ms/sel and receives
//                dat_sm/ack/err; slave modport is the mirror image.
//  Revision    : 1.0  initial release
// ============================================================================
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel,
        output dat_sm, ack, err
    );
endinterface
`default_nettype wire

// File: rtl/wshb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arb_mux
//  Description : Purely combinational owner-select routing between two
//                Wishbone requesters and one shared target.
//  Ports       : i_own[1:0]       one-hot current owner (00 = nobody)
//                i_abort_err[1:0] one-hot err injection for a timed-out owner
//                ifs0, ifs1       requester bundles (slave side)
//                ifm              shared target bundle (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module wshb_arb_mux (
    input  wire logic [1:0] i_own,
    input  wire logic [1:0] i_abort_err,
    wshb_if.slave           ifs0,
    wshb_if.slave           ifs1,
    wshb_if.master          ifm
);

    // Requester -> target: only the owner reaches the bus, otherwise all zero.
    assign ifm.cyc    = i_own[0] ? ifs0.cyc    : (i_own[1] ? ifs1.cyc    : 1'b0);
    assign ifm.stb    = i_own[0] ? ifs0.stb    : (i_own[1] ? ifs1.stb    : 1'b0);
    assign ifm.we     = i_own[0] ? ifs0.we     : (i_own[1] ? ifs1.we     : 1'b0);
    assign ifm.adr    = i_own[0] ? ifs0.adr    : (i_own[1] ? ifs1.adr    : '0);
    assign ifm.dat_ms = i_own[0] ? ifs0.dat_ms : (i_own[1] ? ifs1.dat_ms : '0);
    assign ifm.sel    = i_own[0] ? ifs0.sel    : (i_own[1] ? ifs1.sel    : '0);

    // Target -> requester: responses reach the owner only; a non-owner sees
    // a quiet bus so its pending request simply waits.
    assign ifs0.ack    = i_own[0] & ifm.ack;
    assign ifs0.err    = (i_own[0] & ifm.err) | i_abort_err[0];
    assign ifs0.dat_sm = i_own[0] ? ifm.dat_sm : '0;

    assign ifs1.ack    = i_own[1] & ifm.ack;
    assign ifs1.err    = (i_own[1] & ifm.err) | i_abort_err[1];
    assign ifs1.dat_sm = i_own[1] ? ifm.dat_sm : '0;

endmodule
`default_nettype wire

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arbiter
//  Description : Two-requester round-robin Wishbone arbiter with burst hold
//                and ack timeout. Requester 0 is the video frame-buffer
//                reader, requester 1 the pattern/image writer.
//  Ports       : clk        clock, rising edge
//                rst_n      synchronous active-low reset
//                wshb_ifs0  requester 0 bundle (slave side)
//                wshb_ifs1  requester 1 bundle (slave side)
//                wshb_ifm   shared SDRAM-side target (master side)
//                grant[1:0] one-hot current owner, 00 when nobody owns
//  Revision    : 1.0  initial release
// ============================================================================
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    wshb_if.slave           wshb_ifs0,
    wshb_if.slave           wshb_ifs1,
    wshb_if.master          wshb_ifm,
    output logic [1:0]      grant
);

    generate
        if (TIMEOUT < 2 || DATA_BYTES < 1 || ADDR_WIDTH < 1) begin : g_param_check
            $error("wshb_arbiter: TIMEOUT must be >= 2 and widths positive");
        end
    endgenerate

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_OWN0  = OWN0;
    localparam logic [1:0] c_OWN1  = OWN1;
    localparam logic [1:0] c_ABORT = ABORT;

    localparam int              c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(TIMEOUT);

    logic [1:0]      r_state;
    logic            r_last_owner;
    logic [c_CW-1:0] r_cnt;

    logic [1:0]      w_own;
    logic [1:0]      w_abort_err;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_resp;
    logic            w_timeout;

    // Ownership is a pure decode of the state register, so grant never has a
    // combinational path from the request inputs.
    assign w_own[0] = (r_state == c_OWN0);
    assign w_own[1] = (r_state == c_OWN1);
    assign grant    = w_own;

    assign w_own_cyc = w_own[0] ? wshb_ifs0.cyc : (w_own[1] & wshb_ifs1.cyc);
    assign w_own_stb = w_own[0] ? wshb_ifs0.stb : (w_own[1] & wshb_ifs1.stb);
    assign w_resp    = wshb_ifm.ack | wshb_ifm.err;

    // A response in the last allowed cycle wins over the abort.
    assign w_timeout = w_own_stb & ~w_resp & (r_cnt == c_CNT_LAST);

    // last_owner already names the timed-out requester while in ABORT.
    assign w_abort_err = (r_state == c_ABORT) ? (r_last_owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
                        // Contest: serve whoever was not served last.
                        r_state <= r_last_owner ? c_OWN0 : c_OWN1;
                    end else if (wshb_ifs0.cyc) begin
                        r_state <= c_OWN0;
                    end else if (wshb_ifs1.cyc) begin
                        r_state <= c_OWN1;
                    end
                end
                c_OWN0, c_OWN1: begin
                    if (!w_own_cyc) begin
                        r_state      <= c_IDLE;
                        r_last_owner <= (r_state == c_OWN1);
                        r_cnt        <= '0;
                    end else if (w_timeout) begin
                        r_state      <= c_ABORT;
                        r_last_owner <= (r_state == c_OWN1);
                        r_cnt        <= '0;
                    end else if (w_resp) begin
                        r_cnt <= '0;
                    end else if (w_own_stb && (r_cnt != c_CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ABORT: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    wshb_arb_mux u_mux (
        .i_own       (w_own),
        .i_abort_err (w_abort_err),
        .ifs0        (wshb_ifs0),
        .ifs1        (wshb_ifs1),
        .ifm         (wshb_ifm)
    );

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_arbiter
//  Description : Self-checking bench for wshb_arbiter (TIMEOUT = 8): a table
//                of per-cycle vectors followed by hand-written sequences for
//                long reads, burst hold, timeout, late ack and mid-burst reset.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wshb_arbiter;

    typedef struct packed {
        logic        c0, s0, w0;
        logic [31:0] a0, d0;
        logic [3:0]  l0;
        logic        c1, s1, w1;
        logic [31:0] a1, d1;
        logic [3:0]  l1;
        logic        ta, te;
        logic [31:0] td;
    } in_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        mc, ms, mw;
        logic [31:0] ma, md;
        logic [3:0]  ml;
        logic        a0, e0;
        logic [31:0] r0;
        logic        a1, e1;
        logic [31:0] r1;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    in_t        vin;
    out_t       act;
    int         checks;
    int         errors;

    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) ifs0 ();
    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) ifs1 ();
    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) ifm ();

    assign ifs0.cyc    = vin.c0;
    assign ifs0.stb    = vin.s0;
    assign ifs0.we     = vin.w0;
    assign ifs0.adr    = vin.a0;
    assign ifs0.dat_ms = vin.d0;
    assign ifs0.sel    = vin.l0;
    assign ifs1.cyc    = vin.c1;
    assign ifs1.stb    = vin.s1;
    assign ifs1.we     = vin.w1;
    assign ifs1.adr    = vin.a1;
    assign ifs1.dat_ms = vin.d1;
    assign ifs1.sel    = vin.l1;
    assign ifm.ack     = vin.ta;
    assign ifm.err     = vin.te;
    assign ifm.dat_sm  = vin.td;

    assign act = {grant, ifm.cyc, ifm.stb, ifm.we, ifm.adr, ifm.dat_ms, ifm.sel,
                  ifs0.ack, ifs0.err, ifs0.dat_sm, ifs1.ack, ifs1.err, ifs1.dat_sm};

    wshb_arbiter #(.DATA_BYTES(4), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wshb_ifs0 (ifs0),
        .wshb_ifs1 (ifs1),
        .wshb_ifm  (ifm),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(
        input logic c0, s0, w0, input logic [31:0] a0, d0, input logic [3:0] l0,
        input logic c1, s1, w1, input logic [31:0] a1, d1, input logic [3:0] l1,
        input logic ta, te, input logic [31:0] td);
        in_t v;
        v = {c0, s0, w0, a0, d0, l0, c1, s1, w1, a1, d1, l1, ta, te, td};
        return v;
    endfunction

    function automatic out_t mk_ex(
        input logic [1:0] g, input logic mc, ms, mw, input logic [31:0] ma, md,
        input logic [3:0] ml, input logic a0, e0, input logic [31:0] r0,
        input logic a1, e1, input logic [31:0] r1);
        out_t o;
        o = {g, mc, ms, mw, ma, md, ml, a0, e0, r0, a1, e1, r1};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; return at the
    // falling edge so outputs can be sampled.
    task automatic step(input in_t v);
        @(posedge clk);
        #1;
        vin = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        vin   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin : main
        in_t v;
        int  n_ack0, n_ack1, n_bad, n_err;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        vin    = '0;

        // ---------------- per-cycle vector table ----------------
        vt[0]  = '{mk_in(0,0,0,0,0,0,          0,0,0,0,0,0,           1,0,32'hDEADBEEF), mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[1]  = '{mk_in(1,1,0,'h100,'h11,4'hF, 0,0,0,0,0,0,           0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[2]  = '{mk_in(1,1,0,'h100,'h11,4'hF, 0,0,0,0,0,0,           0,0,0),   mk_ex(2'b01,1,1,0,'h100,'h11,4'hF,0,0,0,0,0,0)};
        vt[3]  = '{mk_in(1,1,0,'h100,'h11,4'hF, 0,0,0,0,0,0,           1,0,32'hAAAA0001), mk_ex(2'b01,1,1,0,'h100,'h11,4'hF,1,0,32'hAAAA0001,0,0,0)};
        vt[4]  = '{mk_in(1,1,0,'h104,'h12,4'hF, 1,1,1,'h200,'h22,4'h3, 1,0,32'hAAAA0002), mk_ex(2'b01,1,1,0,'h104,'h12,4'hF,1,0,32'hAAAA0002,0,0,0)};
        vt[5]  = '{mk_in(0,0,0,0,0,0,          1,1,1,'h200,'h22,4'h3, 0,0,0),   mk_ex(2'b01,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[6]  = '{mk_in(0,0,0,0,0,0,          1,1,1,'h200,'h22,4'h3, 0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[7]  = '{mk_in(1,1,0,'h300,'h33,4'hF, 1,1,1,'h200,'h22,4'h3, 1,0,'h55), mk_ex(2'b10,1,1,1,'h200,'h22,4'h3,0,0,0,1,0,'h55)};
        vt[8]  = '{mk_in(1,1,0,'h300,'h33,4'hF, 0,0,0,0,0,0,           0,0,0),   mk_ex(2'b10,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[9]  = '{mk_in(1,1,0,'h300,'h33,4'hF, 0,0,0,0,0,0,           0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[10] = '{mk_in(1,1,0,'h300,'h33,4'hF, 0,0,0,0,0,0,           0,1,'h77), mk_ex(2'b01,1,1,0,'h300,'h33,4'hF,0,1,'h77,0,0,0)};
        vt[11] = '{mk_in(1,1,0,'h300,'h33,4'hF, 0,0,0,0,0,0,           0,0,0),   mk_ex(2'b01,1,1,0,'h300,'h33,4'hF,0,0,0,0,0,0)};
        vt[12] = '{mk_in(0,0,0,0,0,0,          0,0,0,0,0,0,           0,0,0),   mk_ex(2'b01,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[13] = '{mk_in(0,0,0,0,0,0,          0,0,0,0,0,0,           0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[14] = '{mk_in(1,1,0,'h400,0,4'hF,   1,1,1,'h500,'h66,4'hF, 0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[15] = '{mk_in(1,1,0,'h400,0,4'hF,   1,1,1,'h500,'h66,4'hF, 1,0,0),   mk_ex(2'b10,1,1,1,'h500,'h66,4'hF,0,0,0,1,0,0)};
        vt[16] = '{mk_in(1,1,0,'h400,0,4'hF,   0,0,0,0,0,0,           0,0,0),   mk_ex(2'b10,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[17] = '{mk_in(1,1,0,'h400,0,4'hF,   0,0,0,0,0,0,           0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[18] = '{mk_in(1,1,0,'h400,0,4'hF,   0,0,0,0,0,0,           0,0,0),   mk_ex(2'b01,1,1,0,'h400,0,4'hF,0,0,0,0,0,0)};
        vt[19] = '{mk_in(0,0,0,0,0,0,          0,0,0,0,0,0,           0,0,0),   mk_ex(2'b01,0,0,0,0,0,0,0,0,0,0,0,0)};
        vt[20] = '{mk_in(0,0,0,0,0,0,          0,0,0,0,0,0,           0,0,0),   mk_ex(2'b00,0,0,0,0,0,0,0,0,0,0,0,0)};

        do_reset();
        chk("reset_state", act, '0);
        for (int i = 0; i < NV; i++) begin
            step(vt[i].i);
            chk($sformatf("vec%0d", i), act, vt[i].e);
        end

        // ---------------- 8 reads by requester 0, ack every third cycle -------
        do_reset();
        v = '0; v.c0 = 1; v.s0 = 1; v.l0 = 4'hF; v.a0 = 32'h1000;
        step(v);
        chk("rd8_no_comb_grant", grant, 2'b00);
        n_ack0 = 0; n_ack1 = 0; n_bad = 0;
        for (int k = 0; k < 24; k++) begin
            v.a0 = 32'h1000 + 32'(4 * (k / 3));
            v.ta = (k % 3 == 2);
            v.td = 32'hC0DE0000 + 32'(k / 3);
            step(v);
            if (k == 0) chk("rd8_grant_latency", grant, 2'b01);
            if (grant !== 2'b01) n_bad++;
            if (act.a0) begin
                n_ack0++;
                if (act.r0 !== v.td) n_bad++;
            end
            if (act.a1 || act.e1 || act.e0) n_ack1++;
        end
        chk("rd8_ack0_count", n_ack0, 8);
        chk("rd8_ack1_count", n_ack1, 0);
        chk("rd8_grant_data", n_bad, 0);
        v = '0;
        step(v);
        step(v);

        // ---------------- 16-word burst by 0 while 1 waits --------------------
        v = '0; v.c0 = 1; v.s0 = 1; v.l0 = 4'hF; v.a0 = 32'h4000;
        step(v);
        v.c1 = 1; v.s1 = 1; v.w1 = 1; v.a1 = 32'h2000; v.d1 = 32'hCAFEF00D; v.l1 = 4'hC;
        v.ta = 1;
        n_bad = 0; n_ack0 = 0;
        for (int k = 0; k < 16; k++) begin
            v.a0 = 32'h4000 + 32'(4 * k);
            v.td = 32'(k);
            step(v);
            if (grant !== 2'b01 || act.a1 || act.ma !== v.a0) n_bad++;
            if (act.a0) n_ack0++;
        end
        chk("burst_hold", n_bad, 0);
        chk("burst_ack0_count", n_ack0, 16);
        v.c0 = 0; v.s0 = 0; v.a0 = 0; v.l0 = 0; v.ta = 0; v.td = 0;
        step(v);
        step(v);
        chk("burst_handover_idle", grant, 2'b00);
        v.ta = 1; v.td = 32'h0BADF00D;
        step(v);
        chk("burst_handover_wr1", {act.gnt, act.mc, act.ms, act.mw, act.ma, act.md, act.ml, act.a1, act.a0},
            {2'b10, 1'b1, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'hC, 1'b1, 1'b0});
        v = '0;
        step(v);
        step(v);

        // ---------------- timeout with no ack (TIMEOUT = 8) -------------------
        do_reset();
        v = '0; v.c0 = 1; v.s0 = 1; v.l0 = 4'hF; v.a0 = 32'h8000;
        step(v);
        n_err = 0;
        for (int k = 1; k <= 8; k++) begin
            step(v);
            if (act.e0 || act.e1) n_err++;
            if (k == 8) chk("to_still_owned", {act.gnt, act.mc, act.ms}, {2'b01, 1'b1, 1'b1});
        end
        chk("to_no_early_err", n_err, 0);
        step(v);
        chk("to_abort_pulse", {act.gnt, act.mc, act.ms, act.e0, act.e1, act.a0},
            {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        v = '0;
        step(v);
        chk("to_back_idle", {act.gnt, act.e0, act.mc}, {2'b00, 1'b0, 1'b0});
        // last_owner became 0 at the abort, so a contest goes to requester 1
        v.c0 = 1; v.s0 = 1; v.c1 = 1; v.s1 = 1;
        step(v);
        step(v);
        chk("to_rr_after_abort", grant, 2'b10);
        v = '0;
        step(v);
        step(v);

        // ---------------- ack exactly in the timeout cycle --------------------
        do_reset();
        v = '0; v.c0 = 1; v.s0 = 1; v.l0 = 4'hF; v.a0 = 32'h9000;
        step(v);
        for (int k = 1; k <= 7; k++) step(v);
        v.ta = 1; v.td = 32'h600D600D;
        step(v);
        chk("late_ack_delivered", {act.a0, act.e0, act.r0}, {1'b1, 1'b0, 32'h600D600D});
        v.ta = 0; v.td = 0;
        n_err = 0;
        for (int k = 9; k <= 16; k++) begin
            step(v);
            if (act.e0 || grant !== 2'b01) n_err++;
        end
        chk("late_ack_no_abort", n_err, 0);
        step(v);
        chk("late_ack_rearmed", {act.gnt, act.e0}, {2'b00, 1'b1});

        // ---------------- reset mid-burst -------------------------------------
        v = '0;
        step(v);
        v.c0 = 1; v.s0 = 1; v.c1 = 1; v.s1 = 1; v.w1 = 1; v.a1 = 32'hA000; v.d1 = 32'h11;
        v.td = 32'h12345678;
        step(v);
        step(v);
        chk("rst_pre_owner1", grant, 2'b10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", act, '0);
        step(v);
        chk("rst_fresh_contest", grant, 2'b01);
        v = '0;
        step(v);
        step(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
